// File: rtl/conv_dma_if.sv
// Bundles the job-request side and the convolution-engine side of conv_dma_sequencer.
// start is a level request sampled only while the sequencer is idle; done pulses for one cycle per finished job.
interface conv_dma_if;
  logic        start;
  logic [71:0] pix;
  logic [71:0] kern;
  logic [3:0]  passes;
  logic        kernel_keep;
  logic [31:0] result_in;
  logic [31:0] dma_port;
  logic        acc_clear;
  logic        acc_enable;
  logic [31:0] result;
  logic        done;
  logic        busy;

  modport master (
    output start, pix, kern, passes, kernel_keep, result_in,
    input  dma_port, acc_clear, acc_enable, result, done, busy
  );

  modport slave (
    input  start, pix, kern, passes, kernel_keep, result_in,
    output dma_port, acc_clear, acc_enable, result, done, busy
  );
endinterface

// File: rtl/conv_dma_sequencer.sv
// Streams a 3x3 pixel window and kernel to a convolution engine, runs the accumulate passes, captures the result.
// Optional kernel reuse across jobs is enabled by defining CONV_SEQ_KERNEL_CACHE_EN.
module conv_dma_sequencer #(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  conv_dma_if.slave  bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, ACC, WAIT} state_t;

  state_t      state_q, state_d;
  logic [71:0] pix_q, kern_q;
  logic [3:0]  passes_q;
  logic [3:0]  hold_cnt;
  logic [2:0]  sel;
  logic [3:0]  pass_cnt;
  logic        skip_q;
  logic        hold_last, load_last, pass_last;
  logic [7:0]  src_b [9];
  logic [2:0]  grp;
  logic [3:0]  b0i;

  assign hold_last = (hold_cnt == 4'(HOLD - 1));
  assign load_last = hold_last && (sel == (skip_q ? 3'd2 : 3'd5));
  // passes==0 behaves as a single pass
  assign pass_last = ({1'b0, pass_cnt} + 5'd1) >= {1'b0, passes_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (load_last) state_d = CLEAR;
      CLEAR:   state_d = ACC;
      ACC:     if (pass_last) state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef CONV_SEQ_KERNEL_CACHE_EN
  logic kern_loaded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            kern_loaded <= 1'b0;
    else if (state_q == LOAD && hold_last && sel == 3'd5) kern_loaded <= 1'b1;
  end
`else
  logic unused_keep;
  assign unused_keep = bus.kernel_keep;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q      <= '0;
      kern_q     <= '0;
      passes_q   <= '0;
      hold_cnt   <= '0;
      sel        <= '0;
      pass_cnt   <= '0;
      skip_q     <= 1'b0;
      bus.result <= '0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= (state_q == WAIT);
      case (state_q)
        IDLE: if (bus.start) begin
          pix_q    <= bus.pix;
          kern_q   <= bus.kern;
          passes_q <= bus.passes;
          hold_cnt <= '0;
          sel      <= '0;
          pass_cnt <= '0;
`ifdef CONV_SEQ_KERNEL_CACHE_EN
          skip_q   <= bus.kernel_keep && kern_loaded;
`else
          skip_q   <= 1'b0;
`endif
        end
        LOAD: begin
          if (hold_last) begin
            hold_cnt <= '0;
            sel      <= sel + 3'd1;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        ACC:  pass_cnt <= pass_cnt + 4'd1;
        WAIT: bus.result <= bus.result_in;
        default: ;
      endcase
    end
  end

  // Selects 0..2 carry pixel rows, 3..5 carry kernel rows; first element lands in the top byte.
  always_comb begin
    for (int i = 0; i < 9; i++) src_b[i] = (sel < 3'd3) ? pix_q[8*i +: 8] : kern_q[8*i +: 8];
    grp = (sel < 3'd3) ? sel : sel - 3'd3;
    b0i = 4'(grp) * 4'd3;
    bus.dma_port = '0;
    if (state_q == LOAD)
      bus.dma_port = {src_b[b0i], src_b[b0i + 4'd1], src_b[b0i + 4'd2], 1'b1, 4'b0000, sel};
  end

  assign bus.acc_clear  = (state_q == CLEAR);
  assign bus.acc_enable = (state_q == ACC);
  assign bus.busy       = (state_q != IDLE);
  assign dbg_state      = state_q;

endmodule

// File: doc/conv_dma_sequencer.md
CONV_DMA_SEQUENCER -- requirements
Module: conv_dma_sequencer

Interface
REQ-001 SHALL provide parameter HOLD, default 2: clock cycles each DMA word is driven, legal range 1..15.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port start  input  1  job request, sampled only in IDLE.
REQ-005 SHALL provide port pix  input  72  pixel window, pixel i at [8i+7:8i], i = 0..8, signed int8.
REQ-006 SHALL provide port kern  input  72  kernel, same packing as pix.
REQ-007 SHALL provide port passes  input  4  number of acc_enable cycles; 0 is treated as 1.
REQ-008 SHALL provide port kernel_keep  input  1  skip kernel reload (CONV_SEQ_KERNEL_CACHE_EN only).
REQ-009 SHALL provide port result_in  input  32  convolution engine result.
REQ-010 SHALL provide port dma_port  output  32  DMA word to the engine.
REQ-011 SHALL provide port acc_clear  output  1  engine accumulator clear.
REQ-012 SHALL provide port acc_enable  output  1  engine accumulate strobe.
REQ-013 SHALL provide port result  output  32  captured result.
REQ-014 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-015 SHALL provide port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, CLEAR, ACC, WAIT with transitions IDLE->LOAD->CLEAR->ACC->WAIT->IDLE.
REQ-017 SHALL, in IDLE with start=1, register pix, kern and passes at that edge and enter LOAD.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL format each DMA word for select s as {b0, b1, b2, 1'b1, 4'b0000, s[2:0]}, where b0 occupies [31:24].
REQ-020 SHALL fill s = 0..2 with pixels 3s, 3s+1, 3s+2 and s = 3..5 with kernel 3(s-3), 3(s-3)+1, 3(s-3)+2, first element in the most significant byte.
REQ-021 SHALL, in LOAD, emit selects 0,1,2,3,4,5 in order, each held stable for exactly HOLD cycles.
REQ-022 SHALL drive dma_port = 0 in every state other than LOAD.
REQ-023 SHALL assert acc_clear for exactly one cycle in CLEAR.
REQ-024 SHALL assert acc_enable for exactly max(passes,1) consecutive cycles in ACC.
REQ-025 SHALL keep acc_clear and acc_enable mutually exclusive and never both high.
REQ-026 SHALL stay in WAIT for one cycle, then load result_in into result at the edge leaving WAIT.
REQ-027 SHALL assert done at that same edge, hold it for exactly one cycle, and deassert busy at that same edge.
REQ-028 SHALL hold result until the next completion or reset.
REQ-029 SHALL assert done exactly 6*HOLD+P+2 edges after the start-accept edge, with P = max(passes,1).
REQ-030 SHALL accept a start asserted during the done cycle, since the FSM is in IDLE then.

Reset
REQ-031 SHALL, while rst=1 and regardless of clock, force state IDLE and drive dma_port, result, acc_clear, acc_enable, done and busy to 0.
REQ-032 SHALL abandon any in-flight job on reset, produce no done for it, and clear the kernel-loaded flag.

Configuration
REQ-033 SHALL, with CONV_SEQ_KERNEL_CACHE_EN defined, keep a kernel-loaded flag that is set when select 5 completes.
REQ-034 SHALL, with CONV_SEQ_KERNEL_CACHE_EN defined, skip selects 3..5 (LOAD lasts 3*HOLD cycles) when kernel_keep=1 at accept and the flag is set.
REQ-035 SHALL, with CONV_SEQ_KERNEL_CACHE_EN defined, send all six words when kernel_keep=1 but the flag is clear.
REQ-036 SHALL, without CONV_SEQ_KERNEL_CACHE_EN, always send all six words and ignore kernel_keep.

Verification
REQ-037 HOLD=2, pix all 0x0A, kern 0x00/0x000100/0x00, passes=1 -> words 0x0A0A0A80, 0x0A0A0A81, 0x0A0A0A82, 0x00000083, 0x00010084, 0x00000085, each 2 cycles; done 15 edges after accept.
REQ-038 pix = 1..9, kern all 1, passes=3 -> acc_enable high exactly 3 cycles, acc_clear one cycle before it; result = result_in sampled at WAIT exit.
REQ-039 start held high through a job -> exactly one job per IDLE visit, and a new job is accepted in the done cycle.
REQ-040 rst pulsed during word 4 -> all outputs 0 immediately (asynchronous), no done; next start restarts from select 0.
REQ-041 cache macro on: first job with kernel_keep=1 -> 6 words; second job with kernel_keep=1 -> 3 words, done at 3*HOLD+P+2 = 9 edges (HOLD=2, P=1).
REQ-042 passes=0 -> acc_enable high exactly one cycle.
